// File: rtl/alu_pkg.sv
// Shared encodings for the execute-ALU issue path: ALUCC codes, ALUOp/funct fields and the
// sequencer state type.
package alu_pkg;

    localparam int ALUCC_W = 4;

    localparam logic [ALUCC_W-1:0] ALUCC_MUL = 4'b0000;
    localparam logic [ALUCC_W-1:0] ALUCC_OR  = 4'b0001;
    localparam logic [ALUCC_W-1:0] ALUCC_ADD = 4'b0010;
    localparam logic [ALUCC_W-1:0] ALUCC_SUB = 4'b0110;

    localparam logic [1:0] ALUOP_MEM    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] ALUOP_RSVD   = 2'b11;

    localparam logic [2:0] F3_ADD_SUB_MUL = 3'b000;
    localparam logic [2:0] F3_OR          = 3'b110;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_t;

endpackage

// File: rtl/alu_decode.sv
// Combinational {aluop, funct3, funct7} -> {ALUCC, is_mul, legal} decoder.
// Illegal encodings report ALUCC_ADD so callers without a trap path can use the code directly.
module alu_decode
    import alu_pkg::*;
(
    input  logic [1:0]         i_aluop,
    input  logic [2:0]         i_funct3,
    input  logic [6:0]         i_funct7,
    output logic [ALUCC_W-1:0] o_alucc,
    output logic               o_is_mul,
    output logic               o_legal
);

    always_comb begin
        o_alucc  = ALUCC_ADD;
        o_is_mul = 1'b0;
        o_legal  = 1'b0;
        case (i_aluop)
            ALUOP_MEM: begin
                o_alucc = ALUCC_ADD;
                o_legal = 1'b1;
            end
            ALUOP_BRANCH: begin
                o_alucc = ALUCC_SUB;
                o_legal = 1'b1;
            end
            ALUOP_RTYPE: begin
                if (i_funct3 == F3_ADD_SUB_MUL && i_funct7 == F7_BASE) begin
                    o_alucc = ALUCC_ADD;
                    o_legal = 1'b1;
                end else if (i_funct3 == F3_ADD_SUB_MUL && i_funct7 == F7_ALT) begin
                    o_alucc = ALUCC_SUB;
                    o_legal = 1'b1;
                end else if (i_funct3 == F3_ADD_SUB_MUL && i_funct7 == F7_MUL) begin
                    o_alucc  = ALUCC_MUL;
                    o_is_mul = 1'b1;
                    o_legal  = 1'b1;
                end else if (i_funct3 == F3_OR && i_funct7 == F7_BASE) begin
                    o_alucc = ALUCC_OR;
                    o_legal = 1'b1;
                end
            end
            ALUOP_RSVD: begin
                o_legal = 1'b0;
            end
            default: begin
                o_legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_issue.sv
// Issue-side sequencer for the 64-bit execute ALU: accept, drive ALU, wait, return result.
// Optional: define ALU_ILLEGAL_TRAP_EN to answer illegal decodes with rsp_err instead of ADD.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | req_ready high, waiting for a request
// ST_EXEC | alu_* driven, down-counting r_cnt until the ALU result is due
// ST_RESP | rsp_valid high, rsp_data/rsp_err held until rsp_ready
module alu_issue
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH    = 64,
    parameter int OPCODE_LENGTH = 4,
    parameter int MUL_CYCLES    = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [1:0]               req_aluop,
    input  logic [2:0]               req_funct3,
    input  logic [6:0]               req_funct7,
    input  logic [DATA_WIDTH-1:0]    req_a,
    input  logic [DATA_WIDTH-1:0]    req_b,
    output logic [DATA_WIDTH-1:0]    alu_srca,
    output logic [DATA_WIDTH-1:0]    alu_srcb,
    output logic [OPCODE_LENGTH-1:0] alu_alucc,
    input  logic [DATA_WIDTH-1:0]    alu_result,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_WIDTH-1:0]    rsp_data,
    output logic                     rsp_err
);

    localparam int            CNT_W   = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MUL = CNT_W'(MUL_CYCLES - 1);

    state_t                   r_state;
    logic                     r_req_ready;
    logic                     r_rsp_valid;
    logic [DATA_WIDTH-1:0]    r_rsp_data;
    logic                     r_rsp_err;
    logic [DATA_WIDTH-1:0]    r_srca;
    logic [DATA_WIDTH-1:0]    r_srcb;
    logic [OPCODE_LENGTH-1:0] r_alucc;
    logic [CNT_W-1:0]         r_cnt;

    logic [ALUCC_W-1:0]       w_alucc;
    logic                     w_is_mul;
    logic                     w_legal;
    logic [ALUCC_W-1:0]       w_alucc_eff;
    logic                     w_is_mul_eff;

    alu_decode u_decode (
        .i_aluop  (req_aluop),
        .i_funct3 (req_funct3),
        .i_funct7 (req_funct7),
        .o_alucc  (w_alucc),
        .o_is_mul (w_is_mul),
        .o_legal  (w_legal)
    );

    // Illegal encodings fall back to a plain ADD when they are not trapped.
    assign w_alucc_eff  = w_legal ? w_alucc : ALUCC_ADD;
    assign w_is_mul_eff = w_is_mul & w_legal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            r_srca      <= '0;
            r_srcb      <= '0;
            r_alucc     <= OPCODE_LENGTH'(ALUCC_ADD);
            r_cnt       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid && r_req_ready) begin
                        r_req_ready <= 1'b0;
`ifdef ALU_ILLEGAL_TRAP_EN
                        if (!w_legal) begin
                            r_state     <= ST_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_data  <= '0;
                            r_rsp_err   <= 1'b1;
                        end else begin
                            r_srca  <= req_a;
                            r_srcb  <= req_b;
                            r_alucc <= OPCODE_LENGTH'(w_alucc_eff);
                            r_cnt   <= w_is_mul_eff ? CNT_MUL : '0;
                            r_state <= ST_EXEC;
                        end
`else
                        r_srca  <= req_a;
                        r_srcb  <= req_b;
                        r_alucc <= OPCODE_LENGTH'(w_alucc_eff);
                        r_cnt   <= w_is_mul_eff ? CNT_MUL : '0;
                        r_state <= ST_EXEC;
`endif
                    end
                end
                ST_EXEC: begin
                    if (r_cnt == '0) begin
                        r_rsp_data  <= alu_result;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_req_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign alu_srca  = r_srca;
    assign alu_srcb  = r_srcb;
    assign alu_alucc = r_alucc;
`ifdef ALU_ILLEGAL_TRAP_EN
    assign rsp_err   = r_rsp_err;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a behavioural stand-in for the combinational ALU.
// Honours ALU_ILLEGAL_TRAP_EN for the illegal-op step.
module tb_alu_issue;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_aluop;
    logic [2:0]  req_funct3;
    logic [6:0]  req_funct7;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [63:0] alu_srca;
    logic [63:0] alu_srcb;
    logic [3:0]  alu_alucc;
    logic [63:0] alu_result;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_data;
    logic        rsp_err;

    int n_chk  = 0;
    int n_fail = 0;

    alu_issue #(
        .DATA_WIDTH    (64),
        .OPCODE_LENGTH (4),
        .MUL_CYCLES    (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_aluop  (req_aluop),
        .req_funct3 (req_funct3),
        .req_funct7 (req_funct7),
        .req_a      (req_a),
        .req_b      (req_b),
        .alu_srca   (alu_srca),
        .alu_srcb   (alu_srcb),
        .alu_alucc  (alu_alucc),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in ALU; the expected results below are hand-computed, not taken from this.
    always_comb begin
        alu_result = '0;
        case (alu_alucc)
            4'b0000: alu_result = alu_srca * alu_srcb;
            4'b0001: alu_result = alu_srca | alu_srcb;
            4'b0010: alu_result = alu_srca + alu_srcb;
            4'b0110: alu_result = alu_srca - alu_srcb;
            default: alu_result = '0;
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [63:0] a, input logic [63:0] b);
        req_valid  = 1'b1;
        req_aluop  = op;
        req_funct3 = f3;
        req_funct7 = f7;
        req_a      = a;
        req_b      = b;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, {63'd0, req_ready}, 64'd1);
        chk({tag, "_rsp_valid"}, {63'd0, rsp_valid}, 64'd0);
        chk({tag, "_rsp_data"},  rsp_data, 64'd0);
        chk({tag, "_rsp_err"},   {63'd0, rsp_err}, 64'd0);
        chk({tag, "_srca"},      alu_srca, 64'd0);
        chk({tag, "_srcb"},      alu_srcb, 64'd0);
        chk({tag, "_alucc"},     {60'd0, alu_alucc}, 64'h2);
    endtask

    initial begin
        int lat;
        rst_n      = 1'b0;
        rsp_ready  = 1'b1;
        // Request held during reset must be ignored.
        drive(2'b10, 3'b000, 7'b0000000, 64'd9, 64'd9);
        tick();
        tick();
        chk_reset_outputs("reset");
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk_reset_outputs("post_reset");

        // ADD R-type 5+7
        drive(2'b10, 3'b000, 7'b0000000, 64'd5, 64'd7);
        tick();
        req_valid = 1'b0;
        chk("add_alucc", {60'd0, alu_alucc}, 64'h2);
        chk("add_srca", alu_srca, 64'd5);
        chk("add_srcb", alu_srcb, 64'd7);
        chk("add_ready_low", {63'd0, req_ready}, 64'd0);
        chk("add_valid_e1", {63'd0, rsp_valid}, 64'd0);
        tick();
        chk("add_valid_e2", {63'd0, rsp_valid}, 64'd1);
        chk("add_data", rsp_data, 64'd12);
        chk("add_err", {63'd0, rsp_err}, 64'd0);
        chk("add_ready_resp", {63'd0, req_ready}, 64'd0);
        tick();
        chk("add_valid_drop", {63'd0, rsp_valid}, 64'd0);
        chk("add_ready_back", {63'd0, req_ready}, 64'd1);

        // SUB via branch aluop, wraps
        drive(2'b01, 3'b111, 7'b1111111, 64'd0, 64'd1);
        tick();
        req_valid = 1'b0;
        chk("sub_alucc", {60'd0, alu_alucc}, 64'h6);
        tick();
        chk("sub_valid", {63'd0, rsp_valid}, 64'd1);
        chk("sub_data", rsp_data, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();

        // R-type SUB 10-3
        drive(2'b10, 3'b000, 7'b0100000, 64'd10, 64'd3);
        tick();
        req_valid = 1'b0;
        chk("rsub_alucc", {60'd0, alu_alucc}, 64'h6);
        tick();
        chk("rsub_data", rsp_data, 64'd7);
        tick();

        // MUL, low 64 bits, latency 4
        drive(2'b10, 3'b000, 7'b0000001, 64'h1_0000_0000, 64'h1_0000_0001);
        tick();
        req_valid = 1'b0;
        chk("mul_alucc", {60'd0, alu_alucc}, 64'h0);
        chk("mul_valid_e1", {63'd0, rsp_valid}, 64'd0);
        tick();
        chk("mul_valid_e2", {63'd0, rsp_valid}, 64'd0);
        tick();
        chk("mul_valid_e3", {63'd0, rsp_valid}, 64'd0);
        tick();
        chk("mul_valid_e4", {63'd0, rsp_valid}, 64'd1);
        chk("mul_data", rsp_data, 64'h1_0000_0000);
        tick();

        // OR with back-pressure
        rsp_ready = 1'b0;
        drive(2'b10, 3'b110, 7'b0000000, 64'hF0, 64'h0F);
        tick();
        req_valid = 1'b0;
        chk("or_alucc", {60'd0, alu_alucc}, 64'h1);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("or_hold_valid", {63'd0, rsp_valid}, 64'd1);
            chk("or_hold_data", rsp_data, 64'hFF);
            chk("or_hold_ready", {63'd0, req_ready}, 64'd0);
            tick();
        end
        rsp_ready = 1'b1;
        chk("or_last_valid", {63'd0, rsp_valid}, 64'd1);
        tick();
        chk("or_done_valid", {63'd0, rsp_valid}, 64'd0);
        chk("or_done_ready", {63'd0, req_ready}, 64'd1);

        // Reserved aluop
        drive(2'b11, 3'b000, 7'b0000000, 64'd3, 64'd4);
        tick();
        req_valid = 1'b0;
`ifdef ALU_ILLEGAL_TRAP_EN
        chk("ill_valid_e1", {63'd0, rsp_valid}, 64'd1);
        chk("ill_err", {63'd0, rsp_err}, 64'd1);
        chk("ill_data", rsp_data, 64'd0);
        chk("ill_srca_kept", alu_srca, 64'hF0);
        chk("ill_srcb_kept", alu_srcb, 64'h0F);
        chk("ill_alucc_kept", {60'd0, alu_alucc}, 64'h1);
`else
        chk("ill_alucc", {60'd0, alu_alucc}, 64'h2);
        chk("ill_srca", alu_srca, 64'd3);
        chk("ill_valid_e1", {63'd0, rsp_valid}, 64'd0);
        tick();
        chk("ill_valid_e2", {63'd0, rsp_valid}, 64'd1);
        chk("ill_data", rsp_data, 64'd7);
        chk("ill_err", {63'd0, rsp_err}, 64'd0);
`endif
        tick();
        chk("ill_done_ready", {63'd0, req_ready}, 64'd1);

        // Reset during MUL EXEC
        drive(2'b10, 3'b000, 7'b0000001, 64'd3, 64'd5);
        tick();
        req_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        tick();
        tick();
        chk("midreset_hold_valid", {63'd0, rsp_valid}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("after_reset_no_rsp", {63'd0, rsp_valid}, 64'd0);
        end

        // Fresh MUL after reset, bounded wait
        drive(2'b10, 3'b000, 7'b0000001, 64'd3, 64'd5);
        tick();
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 12) begin
            tick();
            lat++;
        end
        chk("post_reset_mul_latency", 64'(lat), 64'd4);
        chk("post_reset_mul_data", rsp_data, 64'd15);
        tick();
        chk("post_reset_mul_done", {63'd0, req_ready}, 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
# alu_issue

Issue-side sequencer for the 64-bit execute ALU. Accepts a decoded instruction (ALUOp, funct3, funct7, two operands) over a valid/ready handshake and decodes it into the 4-bit ALUCC code. Drives registered SrcA/SrcB/ALUCC into the combinational ALU and waits the configured number of cycles for multiply. Captures ALUResult and returns it over a second valid/ready handshake to the writeback path.

## Interface
- DATA_WIDTH, 64, operand/result width
- OPCODE_LENGTH, 4, ALUCC width
- MUL_CYCLES, 3, cycles allowed for the ALU multiply path (≥1)
- clk  in  1  sole clock, rising edge
- rst_n  in  1  reset; asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  block can accept (high only in IDLE)
- req_aluop  in  2  00 load/store, 01 branch, 10 R-type, 11 reserved
- req_funct3  in  3  instruction funct3
- req_funct7  in  7  instruction funct7
- req_a, req_b  in  DATA_WIDTH  operands
- alu_srca, alu_srcb  out  DATA_WIDTH  registered ALU operands
- alu_alucc  out  OPCODE_LENGTH  registered ALU opcode
- alu_result  in  DATA_WIDTH  combinational ALU output
- rsp_valid  out  1  result present
- rsp_ready  in  1  consumer accepts result
- rsp_data  out  DATA_WIDTH  captured result
- rsp_err  out  1  illegal operation (only with ALU_ILLEGAL_TRAP_EN; else tied 0)

## Operation
- ALUCC map: MUL 0000, OR 0001, ADD 0010, SUB 0110.
- Decode:
  - aluop 00 → ADD; aluop 01 → SUB.
  - aluop 10:
    - f3=000, f7=0000000 → ADD
    - f3=000, f7=0100000 → SUB
    - f3=000, f7=0000001 → MUL
    - f3=110, f7=0000000 → OR
  - All other combinations are illegal.
- States: IDLE, EXEC, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, register req_a, req_b and the decoded ALUCC onto alu_*.
  - Load cnt = MUL ? MUL_CYCLES-1 : 0.
  - Go to EXEC.
- EXEC: if cnt==0, capture alu_result into rsp_data and go to RESP. Otherwise cnt decrements.
- RESP: rsp_valid=1; rsp_data and rsp_err are stable. On rsp_ready, go to IDLE.
- alu_* hold their last values in IDLE/RESP. They change only on request acceptance.
- Arithmetic is performed by the ALU. Results are modulo 2^DATA_WIDTH: SUB wraps, MUL keeps the low DATA_WIDTH bits.

## Timing
- Reset (async assert, sync deassert expected): state IDLE, req_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0, alu_srca=0, alu_srcb=0, alu_alucc=4'b0010, cnt=0.
- Requests presented while rst_n is low are ignored.
- Latency, counted in edges from the acceptance edge to rsp_valid high:
  - ADD/SUB/OR: 2
  - MUL: 1+MUL_CYCLES
  - Illegal with trap: 1
- Response held indefinitely under rsp_ready=0. The handshake edge returns the block to IDLE; req_ready rises the following cycle. No accept occurs on the response edge.
- Peak throughput: one non-MUL op per 3 cycles.
- If rsp_ready is already high when rsp_valid rises, the handshake completes in that one cycle.
- Reset mid-EXEC or mid-RESP: operation dropped, no response, all outputs return to reset values.
- MUL_CYCLES=1: MUL timing is identical to ADD.

## Configuration
- ALU_ILLEGAL_TRAP_EN defined:
  - Illegal decode skips EXEC and goes directly to RESP.
  - rsp_err=1, rsp_data=0.
  - alu_* are not updated.
- ALU_ILLEGAL_TRAP_EN undefined:
  - Illegal decode is treated as ADD with normal ADD timing.
  - rsp_err is constant 0.

## Structure
- Package alu_pkg:
  - ALUCC localparams: ALUCC_MUL, ALUCC_OR, ALUCC_ADD, ALUCC_SUB
  - ALUOp encodings
  - funct3/funct7 constants
  - state enum type
- Sub-module alu_decode: combinational {aluop, funct3, funct7} → {alucc, is_mul, legal}. Instantiated once, shared with future issue stages.

## Test plan
- Reset, then ADD aluop=10, f3=000, f7=0, a=5, b=7, rsp_ready=1 → alu_alucc=0010; rsp_valid on 2nd edge after accept; rsp_data=12; req_ready low until the following cycle.
- SUB via aluop=01, a=0, b=1 → rsp_data=64'hFFFF_FFFF_FFFF_FFFF; alu_alucc=0110.
- MUL f7=0000001, a=64'h1_0000_0000, b=64'h1_0000_0001, MUL_CYCLES=3 → rsp_valid on edge 4; rsp_data=64'h1_0000_0000.
- OR f3=110, a=8'hF0, b=8'h0F, rsp_ready held low 5 cycles → rsp_valid and rsp_data=8'hFF stable throughout; req_ready=0 until after the handshake.
- aluop=11 → with ALU_ILLEGAL_TRAP_EN: rsp_err=1, rsp_data=0, latency 1, alu_* unchanged. Without it: ADD result, rsp_err=0.
- Assert rst_n low during MUL EXEC cycle 2 → rsp_valid never rises; all outputs at reset values; next request completes normally.
